// File: rtl/hcsr04_defs.sv
// Shared state codes, default timing and BCD helpers
// for the HC-SR04 emulator.
package hcsr04_defs;

   typedef enum logic [3:0] {
      ST_INICIAL = 4'd0,
      ST_IDLE    = 4'd1,
      ST_TRIGGER = 4'd2,
      ST_ATRASO  = 4'd3,
      ST_ECO     = 4'd4,
      ST_FIM     = 4'd5
   } estado_t;

   localparam int LARGURA_MIN_PAD = 500;
   localparam int ATRASO_PAD      = 10000;
   localparam int R_PAD           = 2941;
   localparam int TIMEOUT_PAD     = 1900000;

   function automatic logic bcd_valido(input logic [11:0] v);
      return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   function automatic logic [11:0] bcd_dec(input logic [11:0] v);
      logic [3:0] c;
      logic [3:0] d;
      logic [3:0] u;
      {c, d, u} = v;
      if (u != 4'd0) begin
         u = u - 4'd1;
      end else begin
         u = 4'd9;
         if (d != 4'd0) begin
            d = d - 4'd1;
         end else begin
            d = 4'd9;
            c = (c != 4'd0) ? c - 4'd1 : 4'd9;
         end
      end
      return {c, d, u};
   endfunction

endpackage

// File: rtl/contador_bcd_dec.sv
// Three-digit BCD down-counter with load, decrement,
// zero flag and digit-validity flag.
module contador_bcd_dec
   import hcsr04_defs::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        carrega,
   input  logic        decrementa,
   input  logic [11:0] d,
   output logic [11:0] q,
   output logic        zero,
   output logic        valido
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q <= 12'h000;
      end else if (carrega) begin
         q <= d;
      end else if (decrementa) begin
         q <= bcd_dec(q);
      end
   end

   assign zero   = (q == 12'h000);
   assign valido = bcd_valido(q);

endmodule

// File: rtl/emulador_hcsr04.sv
// HC-SR04 ultrasonic sensor emulator: trigger qualification,
// burst delay and distance-proportional echo pulse.
module emulador_hcsr04
   import hcsr04_defs::*;
#(
   parameter int LARGURA_MIN = LARGURA_MIN_PAD,
   parameter int ATRASO      = ATRASO_PAD,
   parameter int R           = R_PAD,
   parameter int TIMEOUT     = TIMEOUT_PAD
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        trigger,
   input  logic [11:0] distancia,
   output logic        echo,
   output logic        pronto,
   output logic [3:0]  db_estado
);

   localparam int TW   = $clog2(LARGURA_MIN + 1);
   localparam int MAXC = (ATRASO > TIMEOUT) ? ATRASO : TIMEOUT;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int MW   = (R > 1) ? $clog2(R) : 1;

   estado_t        estado;
   logic           trig_ant;
   logic           invalido;
   logic [TW-1:0]  cnt_trig;
   logic [CW-1:0]  cnt;
   logic [MW-1:0]  cnt_cm;
   logic [11:0]    valor;
   logic           zero;
   logic           valido;
   logic           carrega;
   logic           decrementa;

   assign carrega = (estado == ST_TRIGGER) && !trigger
                    && (cnt_trig >= TW'(LARGURA_MIN));
   assign decrementa = (estado == ST_ECO) && !invalido
                       && (cnt_cm == MW'(R - 1));

   contador_bcd_dec u_bcd (
      .clock      (clock),
      .reset      (reset),
      .carrega    (carrega),
      .decrementa (decrementa),
      .d          (distancia),
      .q          (valor),
      .zero       (zero),
      .valido     (valido)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado   <= ST_INICIAL;
         trig_ant <= 1'b0;
         invalido <= 1'b0;
         cnt_trig <= '0;
         cnt      <= '0;
         cnt_cm   <= '0;
         echo     <= 1'b0;
         pronto   <= 1'b0;
      end else begin
         trig_ant <= trigger;
         pronto   <= 1'b0;
         unique case (estado)
            ST_INICIAL: estado <= ST_IDLE;
            ST_IDLE: begin
               if (trigger && !trig_ant) begin
                  cnt_trig <= TW'(1);
                  estado   <= ST_TRIGGER;
               end
            end
            ST_TRIGGER: begin
               if (trigger) begin
                  if (cnt_trig < TW'(LARGURA_MIN))
                     cnt_trig <= cnt_trig + TW'(1);
               end else begin
                  cnt_trig <= '0;
                  cnt      <= '0;
                  estado   <= carrega ? ST_ATRASO : ST_IDLE;
               end
            end
            ST_ATRASO: begin
               if (cnt == CW'(ATRASO - 1)) begin
                  cnt      <= '0;
                  cnt_cm   <= '0;
                  invalido <= zero || !valido;
                  echo     <= 1'b1;
                  estado   <= ST_ECO;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_ECO: begin
               // echo ends on the edge that takes the distance to 000
               if (invalido) begin
                  if (cnt == CW'(TIMEOUT - 1)) begin
                     echo   <= 1'b0;
                     pronto <= 1'b1;
                     estado <= ST_FIM;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end else if (cnt_cm == MW'(R - 1)) begin
                  cnt_cm <= '0;
                  if (valor == 12'h001) begin
                     echo   <= 1'b0;
                     pronto <= 1'b1;
                     estado <= ST_FIM;
                  end
               end else begin
                  cnt_cm <= cnt_cm + MW'(1);
               end
            end
            ST_FIM:  estado <= ST_IDLE;
            default: estado <= ST_INICIAL;
         endcase
      end
   end

   assign db_estado = estado;

endmodule

// File: tb/tb_emulador_hcsr04.sv
// Scoreboard bench for emulador_hcsr04: stimulus pushes expected
// echo timing, a monitor measures the DUT and compares.
module tb_emulador_hcsr04;
   import hcsr04_defs::*;

   localparam int LMIN = 5;
   localparam int ATR  = 20;
   localparam int RR   = 10;
   localparam int TOUT = 300;

   typedef struct {
      int atraso;
      int largura;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        trigger;
   logic [11:0] distancia;
   logic        echo;
   logic        pronto;
   logic [3:0]  db_estado;

   exp_t fila[$];
   int   n_cmp;
   int   n_err;
   int   n_rises;
   int   cyc;
   int   last_fall;
   int   rise_cyc;
   bit   spur;
   bit   ep;
   bit   tp;

   emulador_hcsr04 #(
      .LARGURA_MIN (LMIN),
      .ATRASO      (ATR),
      .R           (RR),
      .TIMEOUT     (TOUT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .trigger   (trigger),
      .distancia (distancia),
      .echo      (echo),
      .pronto    (pronto),
      .db_estado (db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nome, input longint atual,
                      input longint esperado);
      n_cmp++;
      if (atual != esperado) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)",
                  nome, atual, esperado, $time);
      end
   endtask

   // Reference: echo width from the decimal value of the BCD distance
   function automatic int esperado(input logic [11:0] d);
      int c;
      int t;
      int u;
      int n;
      c = int'(d[11:8]);
      t = int'(d[7:4]);
      u = int'(d[3:0]);
      if (c > 9 || t > 9 || u > 9) return TOUT;
      n = 100 * c + 10 * t + u;
      if (n == 0) return TOUT;
      return n * RR;
   endfunction

   function automatic logic [11:0] dist_rand();
      logic [3:0] c;
      logic [3:0] d;
      logic [3:0] u;
      c = 4'($urandom_range(0, 1));
      d = 4'($urandom_range(0, 9));
      u = 4'($urandom_range(0, 9));
      case ($urandom_range(0, 5))
         0: u = 4'($urandom_range(10, 15));
         1: d = 4'($urandom_range(10, 15));
         2: begin c = 4'd0; d = 4'd0; u = 4'd0; end
         default: ;
      endcase
      return {c, d, u};
   endfunction

   // Monitor: samples 1 time unit after each rising edge
   initial begin
      exp_t e;
      bit   ab;
      cyc = 0; last_fall = 0; rise_cyc = 0;
      spur = 1'b0; ep = 1'b0; tp = 1'b0; n_rises = 0;
      forever begin
         @(posedge clock);
         #1;
         cyc++;
         if (tp && !trigger) last_fall = cyc;
         if (echo && !ep) begin
            n_rises++;
            if (fila.size() == 0) begin
               chk("unexpected_echo", 1, 0);
               spur = 1'b1;
            end else begin
               spur = 1'b0;
               rise_cyc = cyc;
               chk("echo_delay", cyc - last_fall, fila[0].atraso);
            end
         end
         if (!echo && ep) begin
            ab = !reset;
            if (!spur && fila.size() > 0) begin
               e = fila.pop_front();
               chk("aborted", ab, e.largura < 0);
               if (!ab) chk("echo_width", cyc - rise_cyc, e.largura);
            end
            chk("pronto_on_fall", pronto, ab ? 0 : 1);
         end else if (pronto) begin
            chk("pronto_stray", 1, 0);
         end
         ep = echo;
         tp = trigger;
      end
   end

   task automatic wait_echo(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clock);
         if (echo) ok = 1'b1;
      end
      if (!ok) chk("echo_rise_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (fila.size() != 0 && i < 5000) begin
         @(negedge clock);
         i++;
      end
      if (fila.size() != 0) begin
         chk("idle_timeout", fila.size(), 0);
         fila.delete();
      end
      repeat (3) @(negedge clock);
   endtask

   task automatic pulso(input logic [11:0] d, input int larg);
      exp_t e;
      @(negedge clock);
      distancia = d;
      trigger = 1'b1;
      repeat (larg) @(negedge clock);
      trigger = 1'b0;
      if (larg >= LMIN) begin
         e.atraso  = ATR;
         e.largura = esperado(d);
         fila.push_back(e);
      end
   endtask

   task automatic medir(input logic [11:0] d, input int larg,
                        input bit mexer);
      bit ok;
      pulso(d, larg);
      if (mexer && larg >= LMIN) begin
         repeat (3) @(negedge clock);
         distancia = 12'h999;
         wait_echo(ok);
         if (ok) begin
            repeat (2) @(negedge clock);
            trigger = 1'b1;
            repeat (6) @(negedge clock);
            trigger = 1'b0;
            distancia = dist_rand();
         end
      end
      wait_idle();
   endtask

   initial begin
      bit   ok;
      exp_t e;
      int   r0;
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      trigger = 1'b0;
      distancia = 12'h000;
      repeat (3) @(negedge clock);
      chk("rst_echo", echo, 0);
      chk("rst_pronto", pronto, 0);
      chk("rst_estado", db_estado, ST_INICIAL);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("idle_after_rst", db_estado, ST_IDLE);

      medir(12'h012, 5, 1'b0);

      r0 = n_rises;
      medir(12'h012, 4, 1'b0);
      repeat (1000) @(negedge clock);
      chk("short_no_echo", n_rises - r0, 0);
      chk("short_idle", db_estado, ST_IDLE);

      medir(12'h000, 5, 1'b0);
      medir(12'h0A3, 5, 1'b0);
      medir(12'h003, 5, 1'b1);

      // abort at the 50th echo clock
      pulso(12'h012, 5);
      fila[fila.size() - 1].largura = -1;
      wait_echo(ok);
      if (ok) begin
         repeat (49) @(negedge clock);
         reset = 1'b0;
         #1;
         chk("abort_echo_low", echo, 0);
         chk("abort_estado", db_estado, ST_INICIAL);
         repeat (3) @(negedge clock);
         reset = 1'b1;
      end
      wait_idle();
      medir(12'h012, 5, 1'b0);

      // held trigger across return to IDLE
      pulso(12'h002, 5);
      wait_echo(ok);
      @(negedge clock);
      trigger = 1'b1;
      wait_idle();
      r0 = n_rises;
      repeat (40) @(negedge clock);
      chk("held_idle", db_estado, ST_IDLE);
      trigger = 1'b0;
      repeat (2) @(negedge clock);
      chk("held_no_echo", n_rises - r0, 0);
      medir(12'h004, 5, 1'b0);

      for (int k = 0; k < 10; k++) begin
         medir(dist_rand(), int'($urandom_range(3, 8)),
               1'($urandom_range(0, 1)));
      end

      chk("queue_empty", fila.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/emulador_hcsr04.md
EMULADOR_HCSR04 -- requirements
Module: emulador_hcsr04

Interface
REQ-001 Parameter LARGURA_MIN, default 500: minimum trigger high width in clocks (10 us at 50 MHz).
REQ-002 Parameter ATRASO, default 10000: clocks from accepted trigger fall to echo rise (200 us burst time).
REQ-003 Parameter R, default 2941: echo clocks per centimetre (58.82 us/cm at 20 ns).
REQ-004 Parameter TIMEOUT, default 1900000: echo width in clocks for out-of-range or invalid distance (38 ms).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, exactly as stated in REQ-006 and REQ-007.
REQ-006 clock  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-low; 0 forces the reset state.
REQ-008 trigger  input  1  trigger from the sensor interface, same clock domain, no synchroniser.
REQ-009 distancia  input  12  simulated distance as 3 BCD digits [11:8] hundreds, [7:4] tens, [3:0] units, in cm.
REQ-010 echo  output  1  echo pulse to the sensor interface.
REQ-011 pronto  output  1  one-cycle pulse marking the end of an echo.
REQ-012 db_estado  output  4  current FSM state code, for debug.

Function
REQ-013 FSM states: INICIAL, IDLE, TRIGGER, ATRASO, ECO, FIM. Codes 0, 1, 2, 3, 4, 5, defined in the shared include.
REQ-014 INICIAL -> IDLE unconditionally on the first clock after reset release.
REQ-015 IDLE -> TRIGGER only on a rising edge: trigger=1 in this cycle and trigger=0 in the previous cycle. A trigger held high from an earlier cycle SHALL NOT start a measurement.
REQ-016 TRIGGER counts the consecutive high cycles of trigger. The counter saturates at LARGURA_MIN.
REQ-017 TRIGGER exit on the first cycle trigger=0:
  - count >= LARGURA_MIN -> ATRASO.
  - count < LARGURA_MIN -> IDLE; no echo and no pronto.
REQ-018 distancia SHALL be latched on the TRIGGER -> ATRASO transition. Later changes SHALL NOT affect the current echo.
REQ-019 echo SHALL rise exactly ATRASO clocks after entry into ATRASO (ATRASO -> ECO).
REQ-020 Echo width for a valid distance:
  - Valid means every digit <= 9 and the value N is between 1 and 999.
  - echo SHALL stay high for exactly N*R clocks.
  - Count method: a per-cm counter runs 0..R-1, then the latched BCD value decrements; echo ends when the value reaches 000.
REQ-021 If the latched value is 000 or any digit is > 9, echo SHALL stay high for exactly TIMEOUT clocks.
REQ-022 ECO -> FIM as echo falls. FIM drives pronto=1 for one cycle, then goes to IDLE.
REQ-023 trigger activity in ATRASO, ECO or FIM SHALL be ignored.
REQ-024 echo and pronto SHALL be registered outputs, free of glitches.

Reset
REQ-025 While reset=0: state INICIAL, echo=0, pronto=0, db_estado=0, all counters and the latched distance cleared.
REQ-026 Reset asserted in any state, including mid-echo, SHALL drop echo within the same reset assertion. No pronto SHALL be emitted for the aborted measurement.

Structure
REQ-027 State codes and the default timing constants SHALL live in a shared include file, hcsr04_defs, which is also used by the interface testbenches.
REQ-028 The 3-digit BCD down-counter with load, decrement and zero flag SHALL be a sub-module, contador_bcd_dec.
REQ-029 The remaining counters (trigger width, delay/timeout, per-cm) and the FSM SHALL be in emulador_hcsr04.

Verification (bench overrides: LARGURA_MIN=5, ATRASO=20, R=10, TIMEOUT=300)
REQ-030 Valid measurement: trigger high 5 cycles, distancia=12'h012 -> echo rises 20 clocks after the trigger falls, stays high 120 clocks, pronto pulses once.
REQ-031 Short trigger: trigger high 4 cycles -> return to IDLE, echo stays 0 for 1000 clocks.
REQ-032 Invalid distance: distancia=12'h000, then 12'h0A3 -> echo high exactly 300 clocks each time.
REQ-033 Input changes and retrigger during a measurement: distancia=12'h003 latched, then distancia changed to 12'h999 and trigger pulsed during ECO -> echo high exactly 30 clocks, single pronto.
REQ-034 Reset mid-echo: reset=0 for 3 cycles at the 50th echo clock -> echo=0 immediately, no pronto, and the next valid trigger is measured normally.
REQ-035 Held trigger: trigger held high across the return to IDLE -> no new measurement until trigger goes low and then rises again.
